rand_check: RTL and testbench

Checker and synchronizer for the byte-wide pseudo-random stream produced by `rand_gen`, the 16-bit LFSR that advances 8 steps per cycle. It sits at the receive end of a PRBS link or test path and recovers the generator state from two consecutive received bytes. It then free-runs its own copy of the sequence, compares each received byte against the expected byte, and reports lock status plus a saturating error count. It is used for link bring-up and for self-test of datapaths fed by `rand_gen`.

---
 rtl/rand_check.sv | 155 +++++++++++++++
 tb/tb_rand_check.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rand_check.sv
// rand_check: synchronizer and checker for the byte-wide rand_gen PRBS stream.
// Acquires the generator state from two consecutive bytes, confirms it over
// LOCK_COUNT predicted bytes, then free-runs a local LFSR and counts mismatches.
module rand_check #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic        lock_o,
  output logic        err_o,
  output logic [15:0] err_count_o
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_TH   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_COUNT);
  localparam logic [1:0] HIST_FULL = 2'd2;

  // Eight LFSR steps folded into one: next 16-bit state of rand_gen.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n[15:8] = s[7:0];
    n[0]    = s[0] ^ s[5] ^ s[7] ^ s[8]  ^ s[9]  ^ s[11] ^ s[12];
    n[1]    = s[1] ^ s[6] ^ s[8] ^ s[9]  ^ s[10] ^ s[12] ^ s[13];
    n[2]    = s[2] ^ s[7] ^ s[9] ^ s[10] ^ s[11] ^ s[13] ^ s[14];
    n[3]    = s[3] ^ s[8] ^ s[10] ^ s[11] ^ s[12] ^ s[14] ^ s[15];
    n[4]    = s[0] ^ s[9]  ^ s[11] ^ s[12];
    n[5]    = s[1] ^ s[10] ^ s[12] ^ s[13];
    n[6]    = s[2] ^ s[11] ^ s[13] ^ s[14];
    n[7]    = s[3] ^ s[12] ^ s[14] ^ s[15];
    return n;
  endfunction

  // Saturating increment for the error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state, state_nx;
  logic [15:0] hist, hist_nx;
  logic [1:0]  hist_cnt, hist_cnt_nx;
  logic [3:0]  match_cnt, match_cnt_nx;
  logic [3:0]  miss_cnt, miss_cnt_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic        err_p1, err_nx;
  logic [15:0] err_cnt_p1, err_cnt_nx;

  logic [15:0] hist_pred_p0;
  logic [15:0] lfsr_pred_p0;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;
  logic        seed_match_p0;
  logic        live_miss_p0;

  // Stage p0: predictions from the acquisition history and from the local LFSR.
  assign hist_pred_p0  = lfsr_step(hist);
  assign lfsr_pred_p0  = lfsr_step(lfsr);
  assign match_inc     = match_cnt + 4'd1;
  assign miss_inc      = miss_cnt + 4'd1;
  // An all-zero history is the lockup state and never counts as a match.
  assign seed_match_p0 = (data_i == hist_pred_p0[7:0]) && (hist != 16'h0000);
  assign live_miss_p0  = (data_i != lfsr_pred_p0[7:0]);

  // Next-state and next-output logic for the SEARCH/LOCKED machine.
  always_comb begin
    state_nx     = state;
    hist_nx      = hist;
    hist_cnt_nx  = hist_cnt;
    match_cnt_nx = match_cnt;
    miss_cnt_nx  = miss_cnt;
    lfsr_nx      = lfsr;
    err_nx       = 1'b0;
    err_cnt_nx   = err_cnt_p1;

    if (valid_i) begin
      case (state)
        SEARCH: begin
          hist_nx = {hist[7:0], data_i};
          if (hist_cnt == HIST_FULL) begin
            if (seed_match_p0) begin
              match_cnt_nx = match_inc;
              if (match_inc == LOCK_TH) begin
                state_nx    = LOCKED;
                lfsr_nx     = {hist[7:0], data_i};
                miss_cnt_nx = 4'd0;
              end
            end else begin
              match_cnt_nx = 4'd0;
            end
          end else begin
            hist_cnt_nx = hist_cnt + 2'd1;
          end
        end
        LOCKED: begin
          // The local LFSR free-runs; received data never reseeds it.
          lfsr_nx = lfsr_pred_p0;
          if (live_miss_p0) begin
            err_nx      = 1'b1;
            err_cnt_nx  = sat_inc16(err_cnt_p1);
            miss_cnt_nx = miss_inc;
            if (miss_inc == UNLOCK_TH) begin
              state_nx     = SEARCH;
              hist_cnt_nx  = 2'd0;
              match_cnt_nx = 4'd0;
              miss_cnt_nx  = 4'd0;
            end
          end else begin
            miss_cnt_nx = 4'd0;
          end
        end
      endcase
    end

    // Clear beats a simultaneous increment; the err pulse is unaffected.
    if (clear_i) begin
      err_cnt_nx = 16'h0000;
    end
  end

  // Stage p1: state, history, local LFSR and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      hist       <= 16'h0000;
      hist_cnt   <= 2'd0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      lfsr       <= 16'h0000;
      err_p1     <= 1'b0;
      err_cnt_p1 <= 16'h0000;
    end else begin
      state      <= state_nx;
      hist       <= hist_nx;
      hist_cnt   <= hist_cnt_nx;
      match_cnt  <= match_cnt_nx;
      miss_cnt   <= miss_cnt_nx;
      lfsr       <= lfsr_nx;
      err_p1     <= err_nx;
      err_cnt_p1 <= err_cnt_nx;
    end
  end

  assign lock_o      = (state == LOCKED);
  assign err_o       = err_p1;
  assign err_count_o = err_cnt_p1;

endmodule

// File: tb/tb_rand_check.sv
// tb_rand_check: directed scoreboard bench for rand_check.
module tb_rand_check;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        clear_i;
  logic        lock_o;
  logic        err_o;
  logic [15:0] err_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        lock;
    logic        err;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  // Parity masks: bit i of the next generator byte is the parity of s & mask[i].
  localparam logic [15:0] TAP_MASK [8] = '{16'h1BA1, 16'h3742, 16'h6E84, 16'hDD08,
                                           16'h1A01, 16'h3402, 16'h6804, 16'hD008};

  logic [15:0] gen_state;
  int          gen_idx;

  rand_check #(
    .LOCK_COUNT  (4),
    .UNLOCK_COUNT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .clear_i    (clear_i),
    .lock_o     (lock_o),
    .err_o      (err_o),
    .err_count_o(err_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] model_byte(input logic [15:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(s & TAP_MASK[i]);
    return b;
  endfunction

  task automatic gen_reset();
    gen_idx   = 0;
    gen_state = 16'h0000;
  endtask

  // rand_gen stream after its reset: FF, F9, then model-predicted bytes.
  task automatic gen_next(output logic [7:0] b);
    if (gen_idx == 0)      b = 8'hFF;
    else if (gen_idx == 1) b = 8'hF9;
    else                   b = model_byte(gen_state);
    gen_state = {gen_state[7:0], b};
    gen_idx++;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (lock_o === e.lock) else begin
      errors++;
      $error("FAIL %s lock_o got %0b want %0b", e.tag, lock_o, e.lock);
    end
    checks++;
    assert (err_o === e.err) else begin
      errors++;
      $error("FAIL %s err_o got %0b want %0b", e.tag, err_o, e.err);
    end
    checks++;
    assert (err_count_o === e.cnt) else begin
      errors++;
      $error("FAIL %s err_count_o got %h want %h", e.tag, err_count_o, e.cnt);
    end
  endtask

  // Drive one cycle, queue the outputs expected after its edge, then compare.
  task automatic step(input logic [7:0] d, input logic v, input logic c,
                      input logic el, input logic ee, input logic [15:0] ec,
                      input string tag);
    exp_t e;
    data_i  = d;
    valid_i = v;
    clear_i = c;
    e.lock  = el;
    e.err   = ee;
    e.cnt   = ec;
    e.tag   = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d;
    int         nb;

    rst     = 1'b1;
    data_i  = 8'h00;
    valid_i = 1'b0;
    clear_i = 1'b0;
    gen_reset();

    // Reset overrides valid and clear.
    step(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "reset");
    step(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "reset_hold");
    rst = 1'b0;

    // Clean stream: lock after beat 6, no errors over 1000 beats.
    for (int k = 1; k <= 1000; k++) begin
      gen_next(b);
      step(b, 1'b1, 1'b0, (k >= 6), 1'b0, 16'h0000, (k <= 6) ? "clean_lock" : "clean_run");
    end

    // Single corrupted beat while locked.
    gen_next(b);
    step(b ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, "bit_flip");
    for (int k = 0; k < 10; k++) begin
      gen_next(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, "after_flip");
    end

    // Clear on an idle cycle, then four substituted beats drop lock.
    step(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, "clear_idle");
    for (int i = 1; i <= 4; i++) begin
      gen_next(b);
      d = (b == 8'h00) ? 8'h5A : 8'h00;
      step(d, 1'b1, 1'b0, (i < 4), 1'b1, 16'(i), "zero_burst");
    end
    for (int k = 1; k <= 8; k++) begin
      gen_next(b);
      step(b, 1'b1, 1'b0, (k >= 6), 1'b0, 16'd4, "relock");
    end

    // All-zero stream never locks.
    rst = 1'b1;
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset2");
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "all_zero");
    end

    // Sparse valid with garbage on idle cycles.
    rst = 1'b1;
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset3");
    rst = 1'b0;
    gen_reset();
    nb = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        nb++;
        gen_next(b);
        step(b, 1'b1, 1'b0, (nb >= 6), 1'b0, 16'h0000, "rand_valid");
      end else begin
        d = 8'($urandom_range(0, 255));
        step(d, 1'b0, 1'b0, (nb >= 6), 1'b0, 16'h0000, "rand_idle");
      end
    end

    // Preload the counter near the top, then drive it into saturation.
    data_i  = 8'h00;
    valid_i = 1'b0;
    clear_i = 1'b0;
    force dut.err_cnt_p1 = 16'hFFFC;
    @(posedge clk);
    #1;
    release dut.err_cnt_p1;
    gen_next(b);
    step(b ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFD, "sat_pre1");
    gen_next(b);
    step(b ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE, "sat_pre2");
    gen_next(b);
    step(b, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, "sat_good1");
    gen_next(b);
    step(b ^ 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, "sat_hit");
    gen_next(b);
    step(b ^ 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, "sat_hold1");
    gen_next(b);
    step(b, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, "sat_good2");
    gen_next(b);
    step(b ^ 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, "sat_hold2");

    // Clear together with a counted error.
    gen_next(b);
    step(b ^ 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, "clear_with_err");
    gen_next(b);
    step(b, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "post_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
